// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - multi-cycle radix-2 shift-add sequencer for the EX-stage 16x16 MUL
module mul_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_valid,
    input  logic [1:0]           op,
    input  logic [5:0]           funct,
    input  logic                 flush,
    input  logic [31:0]          src1,
    input  logic [31:0]          src2,
    output logic                 mul_stall,
    output logic                 mul_busy,
    output logic                 mul_done,
    output logic [2*WIDTH-1:0]   mul_result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   acc_d;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [CNT_W-1:0]     count_q;
    logic [2*WIDTH-1:0]   result_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 start;
    logic                 last_iter;

    // Operand bits above WIDTH and funct[5:4] do not take part in decode or arithmetic.
    logic unused_bits;
    assign unused_bits = ^{src1[31:WIDTH], src2[31:WIDTH], funct[5:4]};

    assign start     = ex_valid & (op == 2'b10) & (funct[3:0] == 4'b1001) & ~flush;
    assign acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign last_iter = (count_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        acc_q    <= '0;
                        mcand_q  <= {{WIDTH{1'b0}}, src1[WIDTH-1:0]};
                        mplier_q <= src2[WIDTH-1:0];
                        count_q  <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Flush wins over completion on the final iteration edge.
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        count_q  <= count_q + 1'b1;
                        if (last_iter) begin
                            result_q <= acc_d;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mul_stall  = rst_n & (busy_q | ((state_q == S_IDLE) & start));
    assign mul_busy   = busy_q;
    assign mul_done   = done_q;
    assign mul_result = result_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - directed and randomized bench for mul_seq_ctrl against an arithmetic model
module tb_mul_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic        flush;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        mul_stall;
    logic        mul_busy;
    logic        mul_done;
    logic [31:0] mul_result;

    int total;
    int bad;
    logic [31:0] model_res;

    mul_seq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .op         (op),
        .funct      (funct),
        .flush      (flush),
        .src1       (src1),
        .src2       (src2),
        .mul_stall  (mul_stall),
        .mul_busy   (mul_busy),
        .mul_done   (mul_done),
        .mul_result (mul_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        return {16'h0, a[15:0]} * {16'h0, b[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_mul(input logic [31:0] a, input logic [31:0] b);
        ex_valid = 1'b1;
        op       = 2'b10;
        funct    = 6'b001001;
        src1     = a;
        src2     = b;
    endtask

    task automatic drive_idle();
        ex_valid = 1'b0;
        op       = 2'b00;
        funct    = 6'b100001;
        flush    = 1'b0;
    endtask

    // Full multiply: start in cycle 0, stall through cycle 16, done in cycle 17 with start still held.
    task automatic mul_op(input logic [31:0] a, input logic [31:0] b, input bit scramble);
        logic [31:0] exp;
        exp = ref_mul(a, b);
        @(negedge clk);
        drive_mul(a, b);
        #1;
        chk("start_stall", {31'b0, mul_stall}, 32'd1);
        chk("start_busy", {31'b0, mul_busy}, 32'd0);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (scramble) begin
                src1     = $urandom;
                src2     = $urandom;
                ex_valid = 1'($urandom_range(0, 1));
            end
            #1;
            if (mul_stall !== 1'b1 || mul_busy !== 1'b1 || mul_done !== 1'b0)
                chk($sformatf("run_c%0d_stall_busy_done", c), {29'b0, mul_stall, mul_busy, mul_done}, 32'b110);
        end
        total++;
        @(negedge clk);
        drive_mul(a, b);
        #1;
        chk("done_pulse", {31'b0, mul_done}, 32'd1);
        chk("done_stall", {31'b0, mul_stall}, 32'd0);
        chk("done_busy", {31'b0, mul_busy}, 32'd0);
        chk("done_result", mul_result, exp);
        model_res = exp;
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        drive_idle();
        #1;
        chk({tag, "_stall"}, {31'b0, mul_stall}, 32'd0);
        chk({tag, "_busy"}, {31'b0, mul_busy}, 32'd0);
        chk({tag, "_done"}, {31'b0, mul_done}, 32'd0);
        chk({tag, "_hold"}, mul_result, model_res);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        model_res = 32'h0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        drive_mul(32'h5, 32'h6);

        // Reset with a matching MUL decoded: stall must be suppressed.
        @(negedge clk);
        #1;
        chk("rst_stall", {31'b0, mul_stall}, 32'd0);
        @(negedge clk);
        #1;
        chk("rst_busy", {31'b0, mul_busy}, 32'd0);
        chk("rst_done", {31'b0, mul_done}, 32'd0);
        chk("rst_result", mul_result, 32'h0);
        drive_idle();
        rst_n = 1'b1;
        idle_check("post_rst");

        mul_op(32'h0000_1234, 32'h0000_0010, 1'b0);
        chk("t1_const", mul_result, 32'h0001_2340);
        idle_check("t1_idle");

        mul_op(32'hABCD_FFFF, 32'h0000_FFFF, 1'b0);
        chk("t2_const", mul_result, 32'hFFFE_0001);
        idle_check("t2_idle");

        mul_op(32'd3, 32'd4, 1'b0);
        chk("t3a_const", mul_result, 32'h0000_000C);
        mul_op(32'd7, 32'd9, 1'b0);
        chk("t3b_const", mul_result, 32'h0000_003F);
        idle_check("t3_idle");

        // Flush in RUN cycle 5 aborts; flush with decode match in IDLE does not start.
        mul_op(32'd3, 32'd4, 1'b0);
        @(negedge clk);
        drive_mul(32'd5, 32'd5);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
        end
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("t4_flush_cycle_busy", {31'b0, mul_busy}, 32'd1);
        @(negedge clk);
        #1;
        chk("t4_after_busy", {31'b0, mul_busy}, 32'd0);
        chk("t4_idle_flush_stall", {31'b0, mul_stall}, 32'd0);
        chk("t4_after_done", {31'b0, mul_done}, 32'd0);
        idle_check("t4_idle");
        chk("t4_const", mul_result, 32'h0000_000C);
        idle_check("t4_idle2");

        // Flush on the final iteration edge beats completion.
        @(negedge clk);
        drive_mul(32'd100, 32'd200);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
        end
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("t4b_last_busy", {31'b0, mul_busy}, 32'd1);
        idle_check("t4b_no_done");

        // Reset asserted in RUN cycle 8 clears everything.
        mul_op(32'd11, 32'd13, 1'b0);
        @(negedge clk);
        drive_mul(32'd2, 32'd3);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_comb_stall", {31'b0, mul_stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_idle();
        #1;
        chk("t5_busy", {31'b0, mul_busy}, 32'd0);
        chk("t5_stall", {31'b0, mul_stall}, 32'd0);
        chk("t5_result", mul_result, 32'h0);
        model_res = 32'h0;
        idle_check("t5_idle");

        // Start held through DONE must not restart from DONE.
        mul_op(32'd6, 32'd7, 1'b0);
        idle_check("t5_norestart");
        idle_check("t5_norestart2");

        // Non-MUL decodes never stall.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ex_valid = 1'b1;
            flush    = 1'b0;
            case (k)
                0: begin op = 2'b10; funct = 6'b100001; end
                1: begin op = 2'b00; funct = 6'b001001; end
                2: begin op = 2'b11; funct = 6'b001001; end
                default: begin op = 2'b01; funct = 6'b001001; end
            endcase
            #1;
            chk($sformatf("t6_nomul_stall_%0d", k), {31'b0, mul_stall}, 32'd0);
            @(negedge clk);
            #1;
            chk($sformatf("t6_nomul_busy_%0d", k), {31'b0, mul_busy}, 32'd0);
        end
        idle_check("t6_idle");

        // Randomized operands, with RUN-time input scrambling and occasional back-to-back issue.
        for (int n = 0; n < 20; n++) begin
            mul_op($urandom, $urandom, 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                idle_check($sformatf("rand_idle_%0d", n));
            end
        end
        mul_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        chk("max_const", mul_result, 32'hFFFE_0001);
        mul_op(32'h0, 32'hFFFF, 1'b0);
        chk("zero_const", mul_result, 32'h0);
        idle_check("final_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
